// File: rtl/slave_if_wr_arb.sv
// Round-robin write arbiter sharing one slave write port among four master_if
// write channels; a grant is held for a whole burst until its Last beat is accepted.
module slave_if_wr_arb #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iMst0WrReq,
  input  logic          iMst0WrValid,
  input  logic [AW-1:0] iMst0WrAddr,
  input  logic [SW-1:0] iMst0WrSel,
  input  logic [DW-1:0] iMst0WrData,
  input  logic          iMst0WrLast,
  output logic          oMst0WrReady,
  input  logic          iMst1WrReq,
  input  logic          iMst1WrValid,
  input  logic [AW-1:0] iMst1WrAddr,
  input  logic [SW-1:0] iMst1WrSel,
  input  logic [DW-1:0] iMst1WrData,
  input  logic          iMst1WrLast,
  output logic          oMst1WrReady,
  input  logic          iMst2WrReq,
  input  logic          iMst2WrValid,
  input  logic [AW-1:0] iMst2WrAddr,
  input  logic [SW-1:0] iMst2WrSel,
  input  logic [DW-1:0] iMst2WrData,
  input  logic          iMst2WrLast,
  output logic          oMst2WrReady,
  input  logic          iMst3WrReq,
  input  logic          iMst3WrValid,
  input  logic [AW-1:0] iMst3WrAddr,
  input  logic [SW-1:0] iMst3WrSel,
  input  logic [DW-1:0] iMst3WrData,
  input  logic          iMst3WrLast,
  output logic          oMst3WrReady,
  output logic          oSlvWrReq,
  output logic          oSlvWrValid,
  output logic [AW-1:0] oSlvWrAddr,
  output logic [SW-1:0] oSlvWrSel,
  output logic [DW-1:0] oSlvWrData,
  output logic          oSlvWrLast,
  input  logic          iSlvWrReady,
  output logic [3:0]    oGrant,
  output logic          oDbgBurst,
  output logic [1:0]    oDbgGntIdx,
  output logic [1:0]    oDbgRrPtr
);

  // Handshake: a beat transfers on a rising iClk edge where oSlvWrValid and
  // iSlvWrReady are both high; the granted master sees that same ready, the
  // others see 0 and must hold their beat unchanged.

  typedef enum logic {ST_IDLE, ST_BURST} st_e;

  st_e        st_q, st_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] rr_q, rr_d;

  logic [3:0]    req, valid, last;
  logic [AW-1:0] addr [4];
  logic [SW-1:0] sel  [4];
  logic [DW-1:0] data [4];
  logic [3:0]    rdy;

  assign req   = {iMst3WrReq,   iMst2WrReq,   iMst1WrReq,   iMst0WrReq};
  assign valid = {iMst3WrValid, iMst2WrValid, iMst1WrValid, iMst0WrValid};
  assign last  = {iMst3WrLast,  iMst2WrLast,  iMst1WrLast,  iMst0WrLast};
  assign addr[0] = iMst0WrAddr;
  assign addr[1] = iMst1WrAddr;
  assign addr[2] = iMst2WrAddr;
  assign addr[3] = iMst3WrAddr;
  assign sel[0]  = iMst0WrSel;
  assign sel[1]  = iMst1WrSel;
  assign sel[2]  = iMst2WrSel;
  assign sel[3]  = iMst3WrSel;
  assign data[0] = iMst0WrData;
  assign data[1] = iMst1WrData;
  assign data[2] = iMst2WrData;
  assign data[3] = iMst3WrData;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  // Descending scan so the candidate closest to rr_q is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_q;
    cand     = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  logic burst;
  logic beat_hs;
  logic last_hs;
  logic abort;

  assign burst   = (st_q == ST_BURST);
  assign beat_hs = valid[gnt_q] & iSlvWrReady;
  assign last_hs = beat_hs & last[gnt_q];
  assign abort   = ~req[gnt_q] & ~valid[gnt_q];

  always_comb begin
    st_d  = st_q;
    gnt_d = gnt_q;
    rr_d  = rr_q;
    case (st_q)
      ST_IDLE: begin
        if (pick_vld) begin
          st_d  = ST_BURST;
          gnt_d = pick_idx;
        end
      end
      ST_BURST: begin
        if (last_hs || abort) begin
          st_d = ST_IDLE;
          rr_d = gnt_q + 2'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      st_q  <= ST_IDLE;
      gnt_q <= 2'd0;
      rr_q  <= 2'd0;
    end else begin
      st_q  <= st_d;
      gnt_q <= gnt_d;
      rr_q  <= rr_d;
    end
  end

  assign oGrant      = burst ? (4'b0001 << gnt_q) : 4'b0000;
  assign rdy         = oGrant & {4{iSlvWrReady}};
  assign oSlvWrReq   = burst;
  assign oSlvWrValid = burst & valid[gnt_q];
  assign oSlvWrLast  = burst & last[gnt_q];
  assign oSlvWrAddr  = burst ? addr[gnt_q] : '0;
  assign oSlvWrSel   = burst ? sel[gnt_q]  : '0;
  assign oSlvWrData  = burst ? data[gnt_q] : '0;

  assign oMst0WrReady = rdy[0];
  assign oMst1WrReady = rdy[1];
  assign oMst2WrReady = rdy[2];
  assign oMst3WrReady = rdy[3];

  assign oDbgBurst  = burst;
  assign oDbgGntIdx = gnt_q;
  assign oDbgRrPtr  = rr_q;

endmodule

// File: tb/tb_slave_if_wr_arb.sv
// Bench for slave_if_wr_arb: directed scenarios then random traffic, checked
// every cycle against a transaction-level arbiter model and a beat scoreboard.
module tb_slave_if_wr_arb;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int BW = AW + SW + DW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    req_v = '0, val_v = '0, last_v = '0;
  logic [AW-1:0] addr_v [4];
  logic [SW-1:0] sel_v  [4];
  logic [DW-1:0] data_v [4];
  logic          slv_rdy = 1'b0;

  logic [3:0]    mst_rdy;
  logic          slv_req, slv_val, slv_last;
  logic [AW-1:0] slv_addr;
  logic [SW-1:0] slv_sel;
  logic [DW-1:0] slv_data;
  logic [3:0]    grant;
  logic          dbg_burst;
  logic [1:0]    dbg_gnt, dbg_rr;

  slave_if_wr_arb #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .iClk(clk), .iRst(rst),
    .iMst0WrReq(req_v[0]), .iMst0WrValid(val_v[0]), .iMst0WrAddr(addr_v[0]),
    .iMst0WrSel(sel_v[0]), .iMst0WrData(data_v[0]), .iMst0WrLast(last_v[0]),
    .oMst0WrReady(mst_rdy[0]),
    .iMst1WrReq(req_v[1]), .iMst1WrValid(val_v[1]), .iMst1WrAddr(addr_v[1]),
    .iMst1WrSel(sel_v[1]), .iMst1WrData(data_v[1]), .iMst1WrLast(last_v[1]),
    .oMst1WrReady(mst_rdy[1]),
    .iMst2WrReq(req_v[2]), .iMst2WrValid(val_v[2]), .iMst2WrAddr(addr_v[2]),
    .iMst2WrSel(sel_v[2]), .iMst2WrData(data_v[2]), .iMst2WrLast(last_v[2]),
    .oMst2WrReady(mst_rdy[2]),
    .iMst3WrReq(req_v[3]), .iMst3WrValid(val_v[3]), .iMst3WrAddr(addr_v[3]),
    .iMst3WrSel(sel_v[3]), .iMst3WrData(data_v[3]), .iMst3WrLast(last_v[3]),
    .oMst3WrReady(mst_rdy[3]),
    .oSlvWrReq(slv_req), .oSlvWrValid(slv_val), .oSlvWrAddr(slv_addr),
    .oSlvWrSel(slv_sel), .oSlvWrData(slv_data), .oSlvWrLast(slv_last),
    .iSlvWrReady(slv_rdy), .oGrant(grant),
    .oDbgBurst(dbg_burst), .oDbgGntIdx(dbg_gnt), .oDbgRrPtr(dbg_rr)
  );

  // reference model: current owner (-1 = none) and highest-priority index
  int m_owner = -1;
  int m_ptr   = 0;

  logic [BW-1:0] mq[4][$];
  logic [BW-1:0] exp_q[4][$];
  int            gnt_log[$];
  logic [3:0]    prev_grant = '0;

  bit auto_mode  = 1'b1;
  bit rand_rdy   = 1'b0;
  int bubble_pct = 0;
  int n_checks   = 0;
  int n_fail     = 0;
  int cyc;

  int t2_exp[5] = '{0, 1, 2, 3, 0};
  int t3_exp[3] = '{2, 3, 0};
  int t5_exp[4] = '{0, 1, 2, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_burst(input int m, input int len);
    logic [BW-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = {AW'($urandom), SW'($urandom), DW'($urandom), (i == len - 1)};
      mq[m].push_back(b);
      exp_q[m].push_back(b);
    end
  endtask

  task automatic drive();
    if (rand_rdy) slv_rdy = ($urandom_range(0, 99) < 70);
    if (auto_mode) begin
      for (int n = 0; n < 4; n++) begin
        if (mq[n].size() != 0) begin
          req_v[n] = 1'b1;
          val_v[n] = ($urandom_range(0, 99) >= bubble_pct);
          {addr_v[n], sel_v[n], data_v[n], last_v[n]} = mq[n][0];
        end else begin
          req_v[n]  = 1'b0;
          val_v[n]  = 1'b0;
          last_v[n] = 1'($urandom);
          addr_v[n] = AW'($urandom);
          sel_v[n]  = SW'($urandom);
          data_v[n] = DW'($urandom);
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0]    eg;
    logic [BW-1:0] e;
    int            o;
    o  = m_owner;
    eg = (o < 0) ? 4'b0000 : (4'b0001 << o);
    chk("grant",     64'(grant),     64'(eg));
    chk("slv_req",   64'(slv_req),   64'(o >= 0));
    chk("dbg_burst", 64'(dbg_burst), 64'(o >= 0));
    chk("mst_rdy",   64'(mst_rdy),   64'(slv_rdy ? eg : 4'b0000));
    chk("rr_ptr",    64'(dbg_rr),    64'(m_ptr[1:0]));
    if (o < 0) begin
      chk("idle_beat", 64'({slv_val, slv_addr, slv_sel, slv_data, slv_last}), 64'(0));
    end else begin
      chk("valid", 64'(slv_val), 64'(val_v[o]));
      chk("beat_mux", 64'({slv_addr, slv_sel, slv_data, slv_last}),
          64'({addr_v[o], sel_v[o], data_v[o], last_v[o]}));
      if (auto_mode && !rst && val_v[o] && slv_rdy) begin
        chk("sb_nonempty", 64'(exp_q[o].size() != 0), 64'(1));
        if (exp_q[o].size() != 0) begin
          e = exp_q[o].pop_front();
          chk("sb_beat", 64'({slv_addr, slv_sel, slv_data, slv_last}), 64'(e));
        end
      end
    end
    if (grant != 4'b0000 && prev_grant == 4'b0000) begin
      for (int i = 0; i < 4; i++) if (grant[i]) gnt_log.push_back(i);
    end
    prev_grant = grant;
  endtask

  task automatic model_update();
    int o;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req_v[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
    end else begin
      o = m_owner;
      if (auto_mode && val_v[o] && slv_rdy && mq[o].size() != 0) void'(mq[o].pop_front());
      if ((val_v[o] && slv_rdy && last_v[o]) || (!req_v[o] && !val_v[o])) begin
        m_owner = -1;
        m_ptr   = (o + 1) % 4;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    drive();
  endtask

  task automatic at_mid();
    #3;
  endtask

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0);
    for (int n = 0; n < 4; n++) if (mq[n].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (busy() && cycles < budget) begin
      step();
      cycles++;
    end
    chk(tag, 64'(cycles < budget), 64'(1));
  endtask

  task automatic do_reset();
    slv_rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    gnt_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 4; n++) begin
      addr_v[n] = '0;
      sel_v[n]  = '0;
      data_v[n] = '0;
    end
    @(posedge clk);
    model_update();
    #1;
    drive();
    step();
    rst = 1'b0;

    // 1: single master, 3-beat burst
    slv_rdy = 1'b1;
    push_burst(1, 3);
    drive();
    step();
    at_mid();
    chk("t1_grant_latency", 64'(grant), 64'(4'b0010));
    run_until_idle("t1_timeout", 20, cyc);
    chk("t1_beat_cycles", 64'(cyc), 64'(3));
    at_mid();
    chk("t1_idle_req", 64'(slv_req), 64'(0));
    step();

    // 2: all masters, back-to-back 2-beat bursts
    do_reset();
    slv_rdy = 1'b1;
    for (int m = 0; m < 4; m++) push_burst(m, 2);
    push_burst(0, 2);
    drive();
    run_until_idle("t2_timeout", 60, cyc);
    chk("t2_cycles", 64'(cyc), 64'(15));
    chk("t2_len", 64'(gnt_log.size()), 64'(5));
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_seq", 64'(gnt_log[i]), 64'(t2_exp[i]));

    // 3: no preemption
    do_reset();
    slv_rdy = 1'b1;
    push_burst(2, 4);
    drive();
    step();
    step();
    push_burst(0, 2);
    push_burst(3, 2);
    run_until_idle("t3_timeout", 60, cyc);
    chk("t3_len", 64'(gnt_log.size()), 64'(3));
    for (int i = 0; i < 3 && i < gnt_log.size(); i++) chk("t3_seq", 64'(gnt_log[i]), 64'(t3_exp[i]));

    // 4: Last held against Ready low
    do_reset();
    slv_rdy = 1'b1;
    push_burst(0, 2);
    drive();
    step();
    step();
    slv_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_mid();
      chk("t4_hold_grant", 64'(grant), 64'(4'b0001));
      chk("t4_hold_last", 64'(slv_last), 64'(1));
      step();
    end
    slv_rdy = 1'b1;
    step();
    at_mid();
    chk("t4_release", 64'(grant), 64'(4'b0000));
    step();

    // 5: reset mid-burst
    do_reset();
    slv_rdy = 1'b1;
    push_burst(1, 4);
    drive();
    step();
    step();
    push_burst(0, 1);
    push_burst(2, 1);
    push_burst(3, 1);
    slv_rdy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    gnt_log.delete();
    at_mid();
    chk("t5_grant", 64'(grant), 64'(0));
    chk("t5_req", 64'(slv_req), 64'(0));
    chk("t5_rr", 64'(dbg_rr), 64'(0));
    chk("t5_beat", 64'({slv_val, slv_addr, slv_sel, slv_data, slv_last}), 64'(0));
    slv_rdy = 1'b1;
    run_until_idle("t5_timeout", 60, cyc);
    chk("t5_len", 64'(gnt_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("t5_seq", 64'(gnt_log[i]), 64'(t5_exp[i]));

    // 6: abort by dropping Req, and no abort while Valid is high
    do_reset();
    auto_mode = 1'b0;
    req_v = 4'b1000;
    val_v = 4'b0000;
    last_v = 4'b0000;
    step();
    at_mid();
    chk("t6_grant", 64'(grant), 64'(4'b1000));
    req_v = 4'b0000;
    step();
    at_mid();
    chk("t6_abort_grant", 64'(grant), 64'(0));
    chk("t6_abort_rr", 64'(dbg_rr), 64'(0));
    req_v = 4'b1000;
    step();
    at_mid();
    req_v = 4'b0000;
    val_v = 4'b1000;
    slv_rdy = 1'b0;
    step();
    at_mid();
    chk("t6_no_abort", 64'(grant), 64'(4'b1000));
    last_v = 4'b1000;
    slv_rdy = 1'b1;
    step();
    at_mid();
    chk("t6_last_release", 64'(grant), 64'(0));
    chk("t6_last_rr", 64'(dbg_rr), 64'(0));
    val_v = 4'b0000;
    last_v = 4'b0000;
    auto_mode = 1'b1;
    step();

    // random traffic
    do_reset();
    rand_rdy   = 1'b1;
    bubble_pct = 20;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 15) push_burst($urandom_range(0, 3), $urandom_range(1, 4));
      step();
    end
    rand_rdy   = 1'b0;
    slv_rdy    = 1'b1;
    bubble_pct = 0;
    run_until_idle("rand_drain_timeout", 2000, cyc);
    for (int m = 0; m < 4; m++) chk("sb_drain", 64'(exp_q[m].size()), 64'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
